// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF step scheduler and its update core.
package lif_pkg;

  localparam int unsigned V_W    = 16;
  localparam int unsigned DIFF_W = V_W + 1;

  typedef logic signed [V_W-1:0]    v16_t;
  typedef logic signed [DIFF_W-1:0] diff_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_UPDATE,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Refractory counter width; never narrower than one bit.
  function automatic int unsigned ref_width(input int unsigned t_ref);
    return (t_ref == 0) ? 1 : $clog2(t_ref + 1);
  endfunction

endpackage

// File: rtl/lif_step_scheduler_if.sv
// Current-memory read port and spike address-event port of the LIF step scheduler.
interface lif_step_scheduler_if
  import lif_pkg::*;
#(
  parameter int unsigned IDX_W = 4
);
  logic [IDX_W-1:0] i_addr;
  v16_t             i_data;
  logic             spk_valid;
  logic             spk_ready;
  logic [IDX_W-1:0] spk_addr;

  modport master (
    output i_addr,
    input  i_data,
    output spk_valid,
    input  spk_ready,
    output spk_addr
  );

  modport slave (
    input  i_addr,
    output i_data,
    input  spk_valid,
    output spk_ready,
    input  spk_addr
  );
endinterface

// File: rtl/lif_update_core.sv
// Combinational LIF membrane update: leak toward the input current, threshold, reset.
// Refractory handling is present only when LIF_REFRACTORY_EN is defined.
module lif_update_core
  import lif_pkg::*;
#(
  parameter v16_t        V_REST    = 16'sd0,
  parameter v16_t        V_TH      = 16'sd10,
  parameter int unsigned TAU_SHIFT = 3
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int unsigned T_REF     = 2,
  localparam int unsigned REF_W    = ref_width(T_REF)
`endif
) (
  input  v16_t             v,
  input  v16_t             i_cur,
`ifdef LIF_REFRACTORY_EN
  input  logic [REF_W-1:0] ref_cnt,
  output logic [REF_W-1:0] ref_next,
`endif
  output v16_t             v_next,
  output logic             fire
);

  diff_t diff;
  diff_t delta;
  v16_t  v_leak;

  // Result always lies between v and i_cur, so dropping the top bit is lossless.
  assign diff   = DIFF_W'(i_cur) - DIFF_W'(v);
  assign delta  = diff >>> TAU_SHIFT;
  assign v_leak = V_W'(DIFF_W'(v) + delta);

  always_comb begin
    v_next = v_leak;
    fire   = 1'b0;
`ifdef LIF_REFRACTORY_EN
    ref_next = ref_cnt;
    if (ref_cnt != '0) begin
      v_next   = V_REST;
      ref_next = ref_cnt - REF_W'(1);
    end else
`endif
    if (v_leak >= V_TH) begin
      v_next = V_REST;
      fire   = 1'b1;
`ifdef LIF_REFRACTORY_EN
      ref_next = REF_W'(T_REF);
`endif
    end
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// Time-multiplexed LIF layer: each step walks all neurons through one shared update core.
// Define LIF_REFRACTORY_EN to add per-neuron refractory counters.
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned  N_NEURONS = 16,
  parameter v16_t         V_REST    = 16'sd0,
  parameter v16_t         V_TH      = 16'sd10,
  parameter int unsigned  TAU_SHIFT = 3,
  parameter int unsigned  T_REF     = 2,
  localparam int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step_start,
  lif_step_scheduler_if.master io,
  output logic                 busy,
  output logic                 step_done,
  output logic [15:0]          step_spikes,
  input  logic [IDX_W-1:0]     rd_addr,
  output v16_t                 rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  if (N_NEURONS < 2 || TAU_SHIFT > 15 || T_REF > 32'h0000_FFFF) begin : g_bad_params
    $error("lif_step_scheduler: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [IDX_W-1:0] i_addr_q, i_addr_d;
  logic [IDX_W-1:0] spk_addr_q, spk_addr_d;
  logic [15:0]      cnt_q, cnt_d, step_spikes_d;
  logic             spk_valid_q, spk_valid_d;
  logic             busy_d, step_done_d;
  logic             v_we, advance, fire;
  v16_t             v_mem [N_NEURONS];
  v16_t             v_next;

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned REF_W = ref_width(T_REF);
  logic [REF_W-1:0] ref_mem [N_NEURONS];
  logic [REF_W-1:0] ref_next;
`endif

  lif_update_core #(
    .V_REST    (V_REST),
    .V_TH      (V_TH),
    .TAU_SHIFT (TAU_SHIFT)
`ifdef LIF_REFRACTORY_EN
    ,
    .T_REF     (T_REF)
`endif
  ) u_core (
    .v        (v_mem[idx_q]),
    .i_cur    (io.i_data),
`ifdef LIF_REFRACTORY_EN
    .ref_cnt  (ref_mem[idx_q]),
    .ref_next (ref_next),
`endif
    .v_next   (v_next),
    .fire     (fire)
  );

  assign idx_inc      = idx_q + IDX_W'(1);
  assign io.i_addr    = i_addr_q;
  assign io.spk_valid = spk_valid_q;
  assign io.spk_addr  = spk_addr_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    i_addr_d      = i_addr_q;
    spk_addr_d    = spk_addr_q;
    spk_valid_d   = 1'b0;
    step_done_d   = 1'b0;
    step_spikes_d = step_spikes;
    v_we          = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (step_start) begin
          idx_d    = '0;
          i_addr_d = '0;
          cnt_d    = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_UPDATE;
      ST_UPDATE: begin
        v_we = 1'b1;
        if (fire) begin
          cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
          spk_valid_d = 1'b1;
          spk_addr_d  = idx_q;
          state_d     = ST_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        if (io.spk_ready) advance = 1'b1;
        else spk_valid_d = 1'b1;
      end
      ST_DONE: begin
        step_spikes_d = cnt_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared exit rule for UPDATE without a spike and for a completed EMIT handshake.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d     = ST_DONE;
        step_done_d = 1'b1;
      end else begin
        idx_d    = idx_inc;
        i_addr_d = idx_inc;
        state_d  = ST_FETCH;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      i_addr_q    <= '0;
      spk_addr_q  <= '0;
      spk_valid_q <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      step_spikes <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      i_addr_q    <= i_addr_d;
      spk_addr_q  <= spk_addr_d;
      spk_valid_q <= spk_valid_d;
      busy        <= busy_d;
      step_done   <= step_done_d;
      step_spikes <= step_spikes_d;
    end
  end

  // Membrane storage; readback sees the value before any same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) v_mem[k] <= V_REST;
      rd_data <= V_REST;
    end else begin
      rd_data <= v_mem[rd_addr];
      if (v_we) v_mem[idx_q] <= v_next;
    end
  end

`ifdef LIF_REFRACTORY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) ref_mem[k] <= '0;
    end else if (v_we) begin
      ref_mem[idx_q] <= ref_next;
    end
  end
`endif

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Randomized self-checking bench for lif_step_scheduler against an arithmetic LIF layer model.
module tb_lif_step_scheduler;
  import lif_pkg::*;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int TAU   = 1;
  localparam int VTH   = 10;
  localparam int VREST = 0;
  localparam int TREF  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          step_start;
  logic          busy;
  logic          step_done;
  logic [15:0]   step_spikes;
  logic [IW-1:0] rd_addr;
  v16_t          rd_data;

  lif_step_scheduler_if #(.IDX_W(IW)) io ();

  lif_step_scheduler #(
    .N_NEURONS (N),
    .V_REST    (16'sd0),
    .V_TH      (16'sd10),
    .TAU_SHIFT (TAU),
    .T_REF     (TREF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .step_start  (step_start),
    .io          (io),
    .busy        (busy),
    .step_done   (step_done),
    .step_spikes (step_spikes),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  // Current memory: one-cycle read latency.
  v16_t cur [N];
  always @(posedge clk) io.i_data <= cur[io.i_addr];

  int errors = 0;
  int checks = 0;
  int mv [N];
`ifdef LIF_REFRACTORY_EN
  int mref [N];
`endif
  int exp_spk [$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = VREST;
`ifdef LIF_REFRACTORY_EN
      mref[k] = 0;
`endif
    end
  endtask

  // One whole layer step, neuron by neuron, straight from the leak/threshold rules.
  task automatic model_step();
    exp_spk.delete();
    for (int k = 0; k < N; k++) begin
      int vn;
      vn = mv[k] + ((int'(cur[k]) - mv[k]) >>> TAU);
`ifdef LIF_REFRACTORY_EN
      if (mref[k] > 0) begin
        mv[k]   = VREST;
        mref[k] = mref[k] - 1;
        continue;
      end
`endif
      if (vn >= VTH) begin
        mv[k] = VREST;
        exp_spk.push_back(k);
`ifdef LIF_REFRACTORY_EN
        mref[k] = TREF;
`endif
      end else begin
        mv[k] = vn;
      end
    end
  endtask

  task automatic read_v(input int k, output int val);
    @(negedge clk);
    rd_addr = IW'(k);
    @(negedge clk);
    val = int'(rd_data);
  endtask

  task automatic check_all(input string tag);
    int val;
    for (int k = 0; k < N; k++) begin
      read_v(k, val);
      chk({tag, " v_mem"}, val, mv[k]);
    end
  endtask

  // mode 0: ready tied high, 1: ready low for stall_n cycles per event, 2: random ready.
  task automatic run_step(input string tag, input int mode, input int stall_n, input int exp_done);
    int   got_spk [$];
    int   c, done_at, stalls, stall_left, unstable, busy_low;
    logic prev_valid, prev_ready, rdy;
    logic [IW-1:0] prev_addr;
    c = 0; done_at = -1; stalls = 0; stall_left = 0; unstable = 0; busy_low = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_addr = '0; rdy = 1'b1;
    model_step();
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    while (done_at < 0 && c < 400) begin
      c++;
      if (busy !== 1'b1) busy_low++;
      if (prev_valid && !prev_ready && (io.spk_valid !== 1'b1 || io.spk_addr !== prev_addr))
        unstable++;
      case (mode)
        1: begin
          if (io.spk_valid && !(prev_valid && !prev_ready)) stall_left = stall_n;
          rdy = (stall_left == 0);
          if (!rdy) stall_left--;
        end
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      io.spk_ready = rdy;
      if (io.spk_valid && !rdy) stalls++;
      if (io.spk_valid && rdy) got_spk.push_back(int'(io.spk_addr));
      if (step_done) done_at = c;
      prev_valid = io.spk_valid;
      prev_ready = rdy;
      prev_addr  = io.spk_addr;
      @(negedge clk);
    end
    io.spk_ready = 1'b1;
    if (done_at < 0) begin
      chk({tag, " step_done timeout"}, 0, 1);
    end else begin
      chk({tag, " done_cycle"}, done_at, 2 * N + 1 + exp_spk.size() + stalls);
      if (exp_done >= 0) chk({tag, " done_literal"}, done_at, exp_done);
    end
    chk({tag, " busy_low_cycles"}, busy_low, 0);
    chk({tag, " spk_unstable"}, unstable, 0);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " done_pulse"}, int'(step_done), 0);
    chk({tag, " step_spikes"}, int'(step_spikes), exp_spk.size());
    chk({tag, " n_events"}, got_spk.size(), exp_spk.size());
    for (int i = 0; i < exp_spk.size() && i < got_spk.size(); i++)
      chk({tag, " spk_addr"}, got_spk[i], exp_spk[i]);
  endtask

  initial begin
    int val;
    reset_n      = 1'b0;
    step_start   = 1'b0;
    rd_addr      = '0;
    io.spk_ready = 1'b1;
    for (int k = 0; k < N; k++) cur[k] = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst step_done", int'(step_done), 0);
    chk("rst spk_valid", int'(io.spk_valid), 0);
    chk("rst spk_addr", int'(io.spk_addr), 0);
    chk("rst i_addr", int'(io.i_addr), 0);
    chk("rst step_spikes", int'(step_spikes), 0);
    chk("rst rd_data", int'(rd_data), VREST);
    reset_n = 1'b1;

    // Quiet layer.
    run_step("t1", 0, 0, 9);
    check_all("t1");

    // Single strong input on neuron 2.
    cur[2] = 16'sd40;
    run_step("t2", 0, 0, 10);
    chk("t2 step_spikes_literal", int'(step_spikes), 1);
    check_all("t2");

    // Constant drive integrates to threshold over three steps.
    cur[2] = '0;
    cur[0] = 16'sd12;
    run_step("t3 s1", 0, 0, 9);
    read_v(0, val); chk("t3 v0 after s1", val, 6);
    run_step("t3 s2", 0, 0, 9);
    read_v(0, val); chk("t3 v0 after s2", val, 9);
    run_step("t3 s3", 0, 0, 10);
    read_v(0, val); chk("t3 v0 after s3", val, 0);
    check_all("t3");

    // Router back-pressure for five cycles.
    cur[0] = '0;
    cur[1] = 16'sd40;
    run_step("t4", 1, 5, 15);
    check_all("t4");

    // Most negative current leaks halfway without wrapping.
    cur[1] = '0;
    cur[3] = 16'sh8000;
    run_step("t5", 0, 0, 9);
    read_v(3, val); chk("t5 v3", val, -16384);
    check_all("t5");

    // Reset in the middle of a step.
    cur[0] = 16'sd5; cur[1] = 16'sd6; cur[2] = 16'sd7; cur[3] = 16'sd8;
    run_step("t6 pre", 0, 0, -1);
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6 fetch idx", int'(io.i_addr), 2);
    chk("t6 busy before reset", int'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 busy in reset", int'(busy), 0);
    chk("t6 spk_valid in reset", int'(io.spk_valid), 0);
    chk("t6 step_done in reset", int'(step_done), 0);
    chk("t6 i_addr in reset", int'(io.i_addr), 0);
    chk("t6 step_spikes in reset", int'(step_spikes), 0);
    chk("t6 rd_data in reset", int'(rd_data), VREST);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    check_all("t6 after reset");
    run_step("t6 restart", 0, 0, 9);
    check_all("t6 restart");

`ifdef LIF_REFRACTORY_EN
    // Refractory window suppresses steps 2 and 3.
    cur[0] = 16'sd40; cur[1] = '0; cur[2] = '0; cur[3] = '0;
    run_step("t7 s1", 0, 0, -1);
    chk("t7 s1 spikes", int'(step_spikes), 1);
    run_step("t7 s2", 0, 0, -1);
    chk("t7 s2 spikes", int'(step_spikes), 0);
    read_v(0, val); chk("t7 v0 s2", val, 0);
    run_step("t7 s3", 0, 0, -1);
    chk("t7 s3 spikes", int'(step_spikes), 0);
    read_v(0, val); chk("t7 v0 s3", val, 0);
    run_step("t7 s4", 0, 0, -1);
    chk("t7 s4 spikes", int'(step_spikes), 1);
`endif

    // Random currents, including the extremes, with random router readiness.
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 9))
          0:       cur[k] = 16'sh8000;
          1:       cur[k] = 16'sh7FFF;
          default: cur[k] = 16'(int'($urandom_range(0, 60)) - 30);
        endcase
      end
      run_step("rand", 2, 0, -1);
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_step_scheduler.md
# lif_step_scheduler

Time-multiplexed controller for a layer of leaky integrate-and-fire neurons. It holds the membrane state of `N_NEURONS` neurons and, on each `step_start`, walks them in index order through one shared LIF update datapath. It fetches each input current from an external current memory and emits spikes as address events over a valid/ready port. It sits between the synaptic current accumulator, upstream, and the spike router, downstream.

## Interface
- `N_NEURONS`, 16: neurons in the layer, ≥2.
- `IDX_W`, `$clog2(N_NEURONS)`: neuron index width.
- `V_REST`, 0: signed 16-bit reset and post-spike potential.
- `V_TH`, 10: signed 16-bit firing threshold.
- `TAU_SHIFT`, 3: leak shift, 0–15. The effective tau is 2^`TAU_SHIFT`.
- `T_REF`, 2: refractory steps. Used only under `LIF_REFRACTORY_EN`.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `step_start` in 1: begin one time step. Sampled only in IDLE.
- `busy` out 1: high from FETCH through DONE.
- `step_done` out 1: one-cycle pulse at the end of a step.
- `i_addr` out IDX_W: current-memory read address.
- `i_data` in 16: signed input current. Valid exactly one cycle after `i_addr` is presented.
- `spk_valid` out 1: spike event valid.
- `spk_ready` in 1: router accepts the event.
- `spk_addr` out IDX_W: index of the spiking neuron.
- `step_spikes` out 16: spikes counted in the last completed step, saturating at 0xFFFF.
- `rd_addr` in IDX_W: host membrane readback address.
- `rd_data` out 16: registered readback, `V_mem[rd_addr]` one cycle later.

## Operation
- **State.** `V_mem[N_NEURONS]` is a signed 16-bit register array.
- **FSM states:** IDLE, FETCH, UPDATE, EMIT, DONE.
- **IDLE.** On `step_start`=1, set idx=0 and clear the running spike count. Go to FETCH.
  - `step_start` is ignored in every other state.
- **FETCH.** Drive `i_addr`=idx. Go to UPDATE.
- **UPDATE.** Compute the new potential:
  - `V_next = V + ((i_data - V) >>> TAU_SHIFT)`.
  - The difference is computed in 17-bit signed arithmetic with an arithmetic shift, then truncated to 16 bits.
  - The result lies between V and `i_data`, so truncation is lossless and no saturation logic is required.
  - If `V_next >= V_TH` (signed compare): write `V_REST`, increment the count, go to EMIT.
  - Otherwise: write `V_next`. Go to DONE if idx==N_NEURONS-1, else increment idx and go to FETCH.
- **EMIT.**
  - Drive `spk_valid`=1 and `spk_addr`=idx. Both stay stable until `spk_ready`=1.
  - On the handshake, leave EMIT by the same idx rule used in UPDATE.
  - `spk_valid` may be asserted before `spk_ready`. `spk_valid` never depends combinationally on `spk_ready`.
- **DONE.** Pulse `step_done`, load `step_spikes` from the running count, return to IDLE.
- **Readback.** `rd_data` updates every cycle, including when busy. If the same neuron is written in that cycle, `rd_data` returns the pre-write value.
- **Reset.** `reset_n`=0 at any time, including mid-step, aborts the step:
  - FSM goes to IDLE.
  - All `V_mem` = `V_REST`.
  - `busy`, `step_done`, `spk_valid`, `spk_addr`, `i_addr` and `step_spikes` = 0.
  - `rd_data` = `V_REST`.

## Timing
- Without spikes, a `step_start` sampled at cycle t gives FETCH(k) at t+1+2k and UPDATE(k) at t+2+2k.
- DONE, with `step_done`=1, falls at t+2N+1.
- Each spike adds at least 1 cycle (EMIT), plus every cycle that `spk_valid`=1 while `spk_ready`=0.
- `i_addr` is held through UPDATE.
- The earliest next `step_start` accepted is the cycle after DONE.

## Configuration
- **`LIF_REFRACTORY_EN` defined:**
  - Adds a per-neuron refractory counter, `$clog2(T_REF+1)` bits, reset to 0.
  - A spike loads it with `T_REF`.
  - While nonzero, UPDATE writes `V_REST`, cannot spike, and decrements the counter.
  - FETCH/UPDATE timing is unchanged.
- **`LIF_REFRACTORY_EN` undefined:** no counters exist, and `T_REF` is unused.

## Structure
- **Package `lif_pkg`:**
  - FSM state enum.
  - 16-bit membrane/current type.
  - 17-bit difference width constant.
- **Sub-module `lif_update_core`:** purely combinational.
  - Inputs: V, I, refractory count.
  - Outputs: `V_next`, fire, next refractory count.
  - Parameters: `V_REST`, `V_TH`, `TAU_SHIFT`, `T_REF`.
  - The scheduler instantiates it once.

## Test plan
All scenarios use N_NEURONS=4, V_REST=0, V_TH=10, TAU_SHIFT=1, with `spk_ready` tied to 1 unless stated otherwise.

1. All currents 0, one step → no `spk_valid`, `step_done` exactly 9 cycles after `step_start`, all V=0, `step_spikes`=0.
2. I[2]=40, others 0 → one event with `spk_addr`=2, V[2]=0 after the step, `step_spikes`=1, `step_done` at t+10.
3. I[0]=12 held over steps → V[0] reads 6, then 9, then spikes on step 3 and reads back 0.
4. I[1]=40, `spk_ready` low for 5 cycles → `spk_valid`/`spk_addr`=1 stable throughout, `step_done` at t+15.
5. I[3]=-32768, one step → V[3]=-16384 exactly (no wrap), no spike.
6. Assert `reset_n` in FETCH of idx 2 → `busy`=0 immediately, all V=0. The next `step_start` completes a normal 9-cycle step.
7. With `LIF_REFRACTORY_EN`, T_REF=2, I[0]=40 → spikes on steps 1 and 4, V[0]=0 on steps 2–3.
